// File: rtl/frame_pkg.sv
// Shared definitions for the frame FIFO entry layout and the dispatch scheduler.
package frame_pkg;

    // FIFO entry layout: {payload[127:0], channel mask[7:0], word count[3:0]}
    localparam int unsigned FRAME_ENTRY_W = 140;
    localparam int unsigned PAYLOAD_MSB   = 139;
    localparam int unsigned PAYLOAD_LSB   = 12;
    localparam int unsigned CH_LSB        = 4;
    localparam int unsigned CH_W          = 8;
    localparam int unsigned CNT_LSB       = 0;
    localparam int unsigned CNT_FIELD_W   = 4;
    localparam int unsigned MAX_WORDS     = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } sched_state_t;

endpackage

// File: rtl/frame_dispatch_sched_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_dispatch_sched.sv
// Frame dispatch scheduler: reads one FIFO entry at a time and serialises its
// valid words (LSB word first) to the channels selected by the entry mask.
module frame_dispatch_sched #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                clk_in,
    input  logic                                rst_n,
    input  logic                                sched_en,
    input  logic                                fifo_empty,
    output logic                                fifo_r_enable,
    input  logic [frame_pkg::FRAME_ENTRY_W-1:0] data_from_fifo,
    output logic [WORD_W-1:0]                   data_out,
    output logic [NUM_CH-1:0]                   ch_valid,
    input  logic [NUM_CH-1:0]                   ch_ready,
    output logic                                frame_done,
    output logic                                frame_drop,
    output logic [CNT_W-1:0]                    done_cnt,
    output logic [CNT_W-1:0]                    drop_cnt
);
    import frame_pkg::*;

    localparam int unsigned IDX_W     = $clog2(MAX_WORDS);
    localparam int unsigned PAYLOAD_W = MAX_WORDS * WORD_W;
    localparam logic [CNT_FIELD_W-1:0] MAX_CNT = CNT_FIELD_W'(MAX_WORDS);

    sched_state_t state, state_nxt;

    logic [PAYLOAD_W-1:0]   payload, payload_nxt, fifo_payload;
    logic [NUM_CH-1:0]      mask, mask_nxt, fifo_mask, ch_valid_nxt;
    logic [CNT_FIELD_W-1:0] count, count_nxt, fifo_count;
    logic [IDX_W-1:0]       idx, idx_nxt, idx_inc;
    logic [WORD_W-1:0]      data_out_nxt;
    logic                   rd_nxt, done_nxt, drop_nxt;
    logic                   capture, entry_bad, accept, last_word;

    assign fifo_payload = data_from_fifo[PAYLOAD_LSB +: PAYLOAD_W];
    assign fifo_mask    = data_from_fifo[CH_LSB +: NUM_CH];
    assign fifo_count   = data_from_fifo[CNT_LSB +: CNT_FIELD_W];

    // FETCH spans two cycles: the strobe cycle, then the cycle the read data is valid
    assign capture   = (state == FETCH) && !fifo_r_enable;
    assign entry_bad = (fifo_mask == '0) || (fifo_count == '0) || (fifo_count > MAX_CNT);
    assign accept    = (state == SEND) && ((ch_ready & mask) == mask);
    assign last_word = (CNT_FIELD_W'(idx) == (count - CNT_FIELD_W'(1)));
    assign idx_inc   = idx + IDX_W'(1);

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sched_en && !fifo_empty) state_nxt = FETCH;
            FETCH:   if (capture) state_nxt = entry_bad ? IDLE : SEND;
            SEND:    if (accept && last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the captured entry
    always_comb begin
        rd_nxt       = 1'b0;
        done_nxt     = 1'b0;
        drop_nxt     = 1'b0;
        data_out_nxt = data_out;
        ch_valid_nxt = ch_valid;
        payload_nxt  = payload;
        mask_nxt     = mask;
        count_nxt    = count;
        idx_nxt      = idx;
        case (state)
            IDLE: rd_nxt = sched_en && !fifo_empty;
            FETCH: begin
                if (capture) begin
                    if (entry_bad) begin
                        drop_nxt = 1'b1;
                    end else begin
                        payload_nxt  = fifo_payload;
                        mask_nxt     = fifo_mask;
                        count_nxt    = fifo_count;
                        idx_nxt      = '0;
                        data_out_nxt = fifo_payload[WORD_W-1:0];
                        ch_valid_nxt = fifo_mask;
                    end
                end
            end
            SEND: begin
                if (accept) begin
                    if (last_word) begin
                        done_nxt     = 1'b1;
                        ch_valid_nxt = '0;
                        data_out_nxt = '0;
                    end else begin
                        idx_nxt      = idx_inc;
                        data_out_nxt = payload[idx_inc*WORD_W +: WORD_W];
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fifo_r_enable <= 1'b0;
            data_out      <= '0;
            ch_valid      <= '0;
            frame_done    <= 1'b0;
            frame_drop    <= 1'b0;
            payload       <= '0;
            mask          <= '0;
            count         <= '0;
            idx           <= '0;
        end else begin
            fifo_r_enable <= rd_nxt;
            data_out      <= data_out_nxt;
            ch_valid      <= ch_valid_nxt;
            frame_done    <= done_nxt;
            frame_drop    <= drop_nxt;
            payload       <= payload_nxt;
            mask          <= mask_nxt;
            count         <= count_nxt;
            idx           <= idx_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_done_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .inc    (done_nxt),
        .count  (done_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .inc    (drop_nxt),
        .count  (drop_cnt)
    );

endmodule

// File: tb/tb_frame_dispatch_sched.sv
// Scoreboard bench for frame_dispatch_sched with a behavioural frame FIFO.
module tb_frame_dispatch_sched;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         sched_en;
    logic         fifo_empty;
    logic         fifo_r_enable;
    logic [139:0] data_from_fifo;
    logic [15:0]  data_out;
    logic [7:0]   ch_valid;
    logic [7:0]   ch_ready;
    logic         frame_done;
    logic         frame_drop;
    logic [15:0]  done_cnt;
    logic [15:0]  drop_cnt;

    frame_dispatch_sched #(
        .NUM_CH    (8),
        .WORD_W    (16),
        .MAX_WORDS (8),
        .CNT_W     (16)
    ) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .sched_en       (sched_en),
        .fifo_empty     (fifo_empty),
        .fifo_r_enable  (fifo_r_enable),
        .data_from_fifo (data_from_fifo),
        .data_out       (data_out),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .frame_done     (frame_done),
        .frame_drop     (frame_drop),
        .done_cnt       (done_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [7:0]  mask;
        logic [15:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [139:0] fq[$];
    logic [139:0] hold_data;
    logic         hold_valid = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    int rd_seen = 0, done_seen = 0, drop_seen = 0, valid_cycles = 0;
    int hold_cur = 0, hold_max = 0, run = 0, last_run = 0, last_gap = -1;
    int cyc = 0, last_valid_cyc = 0;
    logic had_frame = 1'b0, prev_valid = 1'b0, prev_empty = 1'b1, prev_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait expired, got no event expected one", name);
    endtask

    // Queue an entry in the FIFO and its expected words in the scoreboard
    task automatic push_entry(input logic [127:0] p, input logic [7:0] m, input logic [3:0] c);
        fq.push_back({p, m, c});
        if (m != 8'h00 && c != 4'd0 && c <= 4'd8) begin
            for (int i = 0; i < int'(c); i++) exp_q.push_back({m, p[i*16 +: 16]});
        end
    endtask

    task automatic wait_valid(input int max_cyc);
        int n = 0;
        while (ch_valid == 8'h00 && n < max_cyc) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= max_cyc) timeout("wait_valid");
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (!(exp_q.size() == 0 && fq.size() == 0 && !hold_valid && ch_valid == 8'h00)
               && n < max_cyc) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= max_cyc) timeout("wait_drain");
        repeat (5) @(negedge clk_in);
    endtask

    // FIFO model: data appears the cycle after the read strobe
    initial begin
        fifo_empty     = 1'b1;
        data_from_fifo = '1;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_n) begin
                hold_valid     = 1'b0;
                data_from_fifo = '1;
            end else begin
                data_from_fifo = hold_valid ? hold_data : '1;
                hold_valid     = 1'b0;
                if (fifo_r_enable && fq.size() != 0) begin
                    hold_data  = fq.pop_front();
                    hold_valid = 1'b1;
                end
            end
            fifo_empty = (fq.size() == 0);
        end
    end

    // Monitor: samples just before each rising edge and scores every presented word
    initial begin
        forever begin
            @(negedge clk_in);
            #4;
            cyc++;
            if (!rst_n) begin
                prev_valid = 1'b0;
                run        = 0;
                hold_cur   = 0;
            end else begin
                if (fifo_r_enable) begin
                    rd_seen++;
                    check("rd_gate_empty_en", {30'd0, prev_empty, prev_en}, 32'd1);
                end
                prev_empty = fifo_empty;
                prev_en    = sched_en;
                if (frame_done) done_seen++;
                if (frame_drop) drop_seen++;
                if (frame_done || frame_drop)
                    check("done_drop_exclusive", {31'd0, frame_done & frame_drop}, 32'd0);
                if (ch_valid != 8'h00) begin
                    valid_cycles++;
                    if (!prev_valid && had_frame) last_gap = cyc - last_valid_cyc - 1;
                    run++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {24'd0, ch_valid}, 32'd0);
                    end else begin
                        check("word_mask", {24'd0, ch_valid}, {24'd0, exp_q[0].mask});
                        check("word_data", {16'd0, data_out}, {16'd0, exp_q[0].data});
                        if ((ch_ready & ch_valid) == ch_valid) begin
                            void'(exp_q.pop_front());
                            hold_cur = 0;
                        end else begin
                            hold_cur++;
                            if (hold_cur > hold_max) hold_max = hold_cur;
                        end
                    end
                    last_valid_cyc = cyc;
                    had_frame      = 1'b1;
                end else if (prev_valid) begin
                    last_run = run;
                    run      = 0;
                end
                prev_valid = (ch_valid != 8'h00);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int rd0, dr0, vc0, dn0;
        rst_n    = 1'b0;
        sched_en = 1'b1;
        ch_ready = 8'hFF;
        repeat (2) @(negedge clk_in);

        // Reset state
        check("rst_rd",       {31'd0, fifo_r_enable}, 32'd0);
        check("rst_data",     {16'd0, data_out}, 32'd0);
        check("rst_valid",    {24'd0, ch_valid}, 32'd0);
        check("rst_done",     {31'd0, frame_done}, 32'd0);
        check("rst_drop",     {31'd0, frame_drop}, 32'd0);
        check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // Drops: empty mask, zero count, count above 8
        dr0 = drop_seen;
        vc0 = valid_cycles;
        push_entry(128'h0004_0003_0002_0001_0004_0003_0002_0001, 8'h00, 4'd4);
        push_entry(128'h1111_1111_1111_1111_1111_1111_1111_1111, 8'h10, 4'd0);
        push_entry(128'h2222_2222_2222_2222_2222_2222_2222_2222, 8'h10, 4'd9);
        wait_drain(60);
        check("drop_pulses",   drop_seen - dr0, 32'd3);
        check("drop_cnt",      {16'd0, drop_cnt}, 32'd3);
        check("drop_done_cnt", {16'd0, done_cnt}, 32'd0);
        check("drop_no_valid", valid_cycles - vc0, 32'd0);

        // Unicast, 8 words, all ready
        push_entry(128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'h04, 4'd8);
        wait_drain(60);
        check("uni_run_len",  last_run, 32'd8);
        check("uni_done_cnt", {16'd0, done_cnt}, 32'd1);

        // Multicast with channel 7 stalled for 5 cycles
        hold_max = 0;
        ch_ready = 8'h01;
        push_entry(128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_5A5A_C3C3, 8'h81, 4'd2);
        wait_valid(40);
        for (int k = 0; k < 5; k++) begin
            ch_ready = (k % 2 == 0) ? 8'h01 : 8'h7F;
            @(negedge clk_in);
        end
        ch_ready = 8'h81;
        wait_drain(60);
        check("bp_hold_cycles", hold_max, 32'd5);
        check("bp_done_cnt",    {16'd0, done_cnt}, 32'd2);
        ch_ready = 8'hFF;

        // Back-to-back frames
        rd0 = rd_seen;
        push_entry(128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_2222_1111, 8'h02, 4'd2);
        push_entry(128'hBEEF_BEEF_BEEF_BEEF_BEEF_C0C0_B0B0_A0A0, 8'h30, 4'd3);
        wait_drain(80);
        check("b2b_strobes",  rd_seen - rd0, 32'd2);
        check("b2b_gap",      last_gap, 32'd3);
        check("b2b_done_cnt", {16'd0, done_cnt}, 32'd4);

        // sched_en dropped mid-SEND with a second entry queued
        rd0 = rd_seen;
        dn0 = done_seen;
        ch_ready = 8'h00;
        push_entry(128'h0000_0000_0000_0000_0000_0303_0202_0101, 8'h08, 4'd3);
        push_entry(128'h0000_0000_0000_0000_0000_0000_0000_7777, 8'h40, 4'd1);
        wait_valid(40);
        repeat (2) @(negedge clk_in);
        sched_en = 1'b0;
        ch_ready = 8'hFF;
        begin
            int n = 0;
            while (done_seen == dn0 && n < 30) begin
                @(negedge clk_in);
                n++;
            end
            if (n >= 30) timeout("sched_off_done");
        end
        repeat (10) @(negedge clk_in);
        check("sched_off_strobes", rd_seen - rd0, 32'd1);
        check("sched_off_pending", exp_q.size(), 32'd1);
        check("sched_off_valid",   {24'd0, ch_valid}, 32'd0);
        sched_en = 1'b1;
        wait_drain(60);
        check("sched_on_strobes", rd_seen - rd0, 32'd2);
        check("sched_done_cnt",   {16'd0, done_cnt}, 32'd6);

        // Reset asserted while word 3 of 8 is on the bus
        push_entry(128'h8888_7777_6666_5555_4444_3333_2222_1111, 8'h01, 4'd8);
        wait_valid(40);
        repeat (3) @(negedge clk_in);
        check("pre_rst_word3", {16'd0, data_out}, 32'h4444);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    {24'd0, ch_valid}, 32'd0);
        check("mid_rst_data",     {16'd0, data_out}, 32'd0);
        check("mid_rst_done",     {31'd0, frame_done}, 32'd0);
        check("mid_rst_rd",       {31'd0, fifo_r_enable}, 32'd0);
        check("mid_rst_done_cnt", {16'd0, done_cnt}, 32'd0);
        check("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        exp_q.delete();
        dn0 = done_seen;
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check("post_rst_no_done", done_seen - dn0, 32'd0);
        push_entry(128'h0000_0000_0000_0000_0000_0000_9999_ABCD, 8'h02, 4'd2);
        wait_drain(60);
        check("post_rst_done_cnt", {16'd0, done_cnt}, 32'd1);
        check("post_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_dispatch_sched.md
Name: frame_dispatch_sched

Overview:
- Drains the 140-bit frame FIFO filled by the frame parser. Each entry is {data_128, data_ch[7:0], data_count[3:0]}.
- Decodes the channel mask and serialises the valid 16-bit words, LSB word first, onto a shared output bus.
- Uses a per-channel valid/ready handshake with multicast.
- Sits between the frame FIFO read port and the 8 downstream channel sinks; reports done/drop status and counters.

Parameters:
NUM_CH, 8, number of output channels (width of data_ch mask)
WORD_W, 16, output word width
MAX_WORDS, 8, maximum words per entry (128 / WORD_W)
CNT_W, 16, width of status counters

Ports:
clk_in  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sched_en  input  1  1 = allowed to start new FIFO reads
fifo_empty  input  1  frame FIFO empty flag
fifo_r_enable  output  1  FIFO read strobe; data valid on the next cycle
data_from_fifo  input  140  FIFO read data: [139:12] payload, [11:4] channel mask, [3:0] word count
data_out  output  WORD_W  word presented to the channels
ch_valid  output  NUM_CH  per-channel valid, equal to the mask while sending
ch_ready  input  NUM_CH  per-channel ready
frame_done  output  1  one-cycle pulse when the last word of a frame is accepted
frame_drop  output  1  one-cycle pulse when an entry is discarded
done_cnt  output  CNT_W  frames completed, saturating
drop_cnt  output  CNT_W  entries dropped, saturating

Behaviour:
- Reset (async, rst_n low): state=IDLE; fifo_r_enable=0, data_out=0, ch_valid=0, frame_done=0, frame_drop=0, done_cnt=0, drop_cnt=0. Any in-flight entry is lost.
- All outputs are registered.
- State machine:
  - IDLE: if sched_en & !fifo_empty, pulse fifo_r_enable for exactly one cycle and go to FETCH. Otherwise stay.
  - FETCH: capture data_from_fifo into payload, mask and count registers.
    - If mask==0, count==0 or count>MAX_WORDS: frame_drop pulses next cycle, drop_cnt+1, go to IDLE.
    - Otherwise set idx=0 and go to SEND.
  - SEND: data_out = payload[idx*16 +: 16]; ch_valid = mask.
    - A word is accepted in a cycle where (ch_ready & mask) == mask. Ready on unselected channels is ignored.
    - On acceptance with idx < count-1: idx+1, present the next word on the following cycle with no bubble.
    - On acceptance with idx == count-1: ch_valid=0 next cycle, frame_done pulse, done_cnt+1, go to IDLE.
- Handshake rule: while not accepted, data_out and ch_valid hold stable. No partial acceptance; a multicast word waits for all selected channels.
- Latency:
  - The read strobe is asserted in the cycle after IDLE sees !fifo_empty & sched_en.
  - The first word is valid 2 cycles after the strobe.
  - Back-to-back frames: minimum 3 idle cycles of ch_valid between frames (IDLE, read, FETCH).
- sched_en only gates new reads. Deassertion during FETCH or SEND lets the current frame complete.
- fifo_r_enable is never asserted while fifo_empty=1.
- Counters saturate at all-ones and do not wrap.
- done and drop cannot occur in the same cycle.
- Word order follows the CRC convention: payload[15:0] is sent first.

Decomposition:
- Shared package frame_pkg:
  - FIFO entry field offsets (PAYLOAD_MSB=139, CH_LSB=4, CNT_LSB=0).
  - FRAME_ENTRY_W=140, MAX_WORDS, and the state enum {IDLE, FETCH, SEND}.
  - The frame parser and this block both import it.
- One natural sub-module: sat_counter (CNT_W, inc input, saturating), instantiated twice for done_cnt and drop_cnt.

Test Plan:
- Unicast: entry payload words 0x0001..0x0008, mask=0x04, count=8, ch_ready=all 1. Expected: ch_valid=0x04 for 8 consecutive cycles, data_out 0x0001..0x0008 in order, one frame_done, done_cnt=1.
- Multicast backpressure: mask=0x81, count=2, ch_ready[0]=1 and ch_ready[7]=0 for 5 cycles. Expected: word0 held stable for 5 cycles, then advances; ch_ready on channels 1-6 toggling has no effect.
- Drops: entries with mask=0x00, count=0 and count=9. Expected: 3 frame_drop pulses, drop_cnt=3, ch_valid never asserted, done_cnt=0.
- Back-to-back frames: two entries queued, fifo_empty=0. Expected: exactly 2 read strobes, none while empty, gap of 3 cycles between frames, done_cnt=2.
- sched_en dropped mid-SEND with a second entry queued. Expected: the current frame completes, no further fifo_r_enable until sched_en=1 again.
- Reset mid-SEND (rst_n low 1 cycle at word 3 of 8). Expected: all outputs 0 immediately, no frame_done, the next entry is processed normally after release.
